// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction-fetch slice.
//   - Widths and constants: INSTR_W, ADDR_W, RESET_PC_DEFAULT (MIPS text
//     base), NOP_INSTR.
//   - fetch_state_t: fetch-stage state encoding (RESET, RUN, FLUSH).
//   - word_align(): clears the byte-offset bits of an address.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          ADDR_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of {instr, pc} pairs.
//   clk, reset (sync, active-low) : clock and reset
//   push, wdata                   : write wdata at the tail
//   pop                           : drop the head entry
//   flush                         : empty the FIFO (wins over push/pop)
//   count                         : number of valid entries (0..2)
//   head                          : head entry, meaningful when count != 0
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [2*INSTR_W-1:0]   wdata,
  output logic [1:0]             count,
  output logic [2*INSTR_W-1:0]   head
);

  logic [2*INSTR_W-1:0] mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;

  // Pointers and count carry the reset; storage does not need one because
  // head is only looked at while count != 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the MIPS decoder.
//   clk, reset (sync, active-low)
//   imem_en, imem_addr  : read request to a 1-cycle-latency instruction memory
//   imem_rdata          : word returned the cycle after imem_en
//   instr, instr_pc     : FIFO head presented to the decoder (0 when empty)
//   instr_valid         : head holds a real instruction
//   instr_ready         : decoder accepts; pop = instr_valid & instr_ready
//   redirect, redirect_pc : control-flow change; flushes all wrong-path words
//   dbg_state           : current fetch state (fetch_state_t encoding)
// Handshake: a word is transferred on every rising edge where instr_valid
// and instr_ready are both 1 and redirect is 0; while instr_valid=1 and
// instr_ready=0 the presented word is held unchanged. During a redirect
// cycle instr_valid may be 1 but nothing is transferred.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  fetch_state_t state, state_nxt;

  logic [31:0]          fetch_pc;
  logic [31:0]          inflight_pc;
  logic                 inflight;
  logic [1:0]           count;
  logic [2*INSTR_W-1:0] head;
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [2:0]           occupancy;

  // Words already owned by the stage after this cycle's pop. A pop implies
  // count >= 1, so the subtraction never underflows.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    case (state)
      RESET:   state_nxt = RUN;
      RUN:     state_nxt = redirect ? FLUSH : RUN;
      FLUSH:   state_nxt = redirect ? FLUSH : RUN;
      default: state_nxt = RESET;
    endcase
    if (reset && !redirect) begin
      pop   = instr_valid & instr_ready;
      // A response is only pushed when the cycle it lands in is not a
      // redirect; in a redirect cycle it belongs to the wrong path.
      push  = inflight;
      issue = (occupancy < DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RESET;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      if (redirect)   fetch_pc <= word_align(redirect_pc);
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_rdata, inflight_pc}),
    .count (count),
    .head  (head)
  );

  assign imem_en     = issue;
  assign imem_addr   = reset ? fetch_pc : RESET_PC;
  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? head[2*INSTR_W-1:INSTR_W] : NOP_INSTR;
  assign instr_pc    = instr_valid ? head[INSTR_W-1:0] : 32'h0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_pops       = 0;

  // Scoreboard: addresses issued and not yet delivered, oldest first.
  logic [31:0] exp_q[$];
  logic [31:0] issue_pc;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;

  logic [31:0] prog [40];

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (compared %0d)", n_compared);
    $fatal(1);
  end

  // ---------------- memory model ----------------
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] off;
    off = a - RPC;
    if (off < 32'd160) return prog[off[7:2]];
    return a ^ 32'h5a5a_0000;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= word_at(imem_addr);
  end

  // ---------------- stream monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic p;
    logic exp_en;
    logic [31:0] e;
    if (!reset) begin
      n_compared++;
      if (imem_en !== 1'b0) begin
        n_mismatched++;
        $display("FAIL mon_en_in_reset: imem_en=%b required 0", imem_en);
      end
      exp_q.delete();
      issue_pc  = RPC;
      prev_hold = 1'b0;
    end else begin
      p = instr_valid & instr_ready & ~redirect;
      exp_en = !redirect && ((exp_q.size() - int'(p)) < 2);
      n_compared++;
      if (imem_en !== exp_en) begin
        n_mismatched++;
        $display("FAIL mon_issue: imem_en=%b required %b (outstanding %0d)", imem_en, exp_en, exp_q.size());
      end
      if (prev_hold) begin
        n_compared++;
        if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc) begin
          n_mismatched++;
          $display("FAIL mon_hold: v=%b instr=%h pc=%h required v=1 instr=%h pc=%h",
                   instr_valid, instr, instr_pc, prev_instr, prev_pc);
        end
      end
      if (!instr_valid) begin
        n_compared++;
        if (instr !== 32'h0) begin
          n_mismatched++;
          $display("FAIL mon_nop: instr=%h required 00000000 when empty", instr);
        end
      end
      if (redirect) begin
        exp_q.delete();
        issue_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (p) begin
          n_pops++;
          n_compared++;
          if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("FAIL mon_pop: unexpected word instr=%h pc=%h", instr, instr_pc);
          end else begin
            e = exp_q.pop_front();
            if (instr_pc !== e || instr !== word_at(e)) begin
              n_mismatched++;
              $display("FAIL mon_pop: instr=%h pc=%h required instr=%h pc=%h",
                       instr, instr_pc, word_at(e), e);
            end
          end
        end
        if (imem_en) begin
          n_compared++;
          if (imem_addr !== issue_pc) begin
            n_mismatched++;
            $display("FAIL mon_addr: imem_addr=%h required %h", imem_addr, issue_pc);
          end
          exp_q.push_back(issue_pc);
          issue_pc = issue_pc + 32'd4;
        end
      end
      prev_hold  = !redirect && instr_valid && !instr_ready;
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [31:0] i,
                           input logic [31:0] pc);
    @(negedge clk);
    n_compared++;
    if (instr_valid !== v || instr !== i || instr_pc !== pc) begin
      n_mismatched++;
      $display("FAIL %s: v=%b instr=%h pc=%h required v=%b instr=%h pc=%h",
               name, instr_valid, instr, instr_pc, v, i, pc);
    end
  endtask

  task automatic check_issue(input string name, input logic en, input logic [31:0] addr);
    @(negedge clk);
    n_compared++;
    if (imem_en !== en || (en && imem_addr !== addr)) begin
      n_mismatched++;
      $display("FAIL %s: imem_en=%b addr=%h required en=%b addr=%h",
               name, imem_en, imem_addr, en, addr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      check_out("reset_outputs", 1'b0, 32'h0, 32'h0);
    end
    next_cycle();
    reset = 1'b1;
    check_issue("reset_cycle0", 1'b1, RPC);
    next_cycle();
    check_issue("reset_cycle1", 1'b1, RPC + 32'd4);
    next_cycle();
    check_out("reset_cycle2", 1'b1, 32'h3c01_1001, RPC);
  endtask

  task automatic test_stall();
    next_cycle();
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_out("stall_hold", 1'b1, 32'h3428_0000, RPC + 32'd4);
      n_compared++;
      if (imem_en !== 1'b0) begin
        n_mismatched++;
        $display("FAIL stall_no_issue: imem_en=%b required 0 (cycle %0d)", imem_en, i);
      end
      if (i < 5) next_cycle();
    end
    next_cycle();
    instr_ready = 1'b1;
    check_out("stall_release", 1'b1, 32'h3428_0000, RPC + 32'd4);
    next_cycle();
    check_out("stall_resume", 1'b1, 32'h000d_2820, RPC + 32'd8);
  endtask

  task automatic test_redirect();
    int  budget = 40;
    bit  found  = 0;
    while (!found && budget > 0) begin
      next_cycle();
      budget--;
      if (instr_valid && instr == 32'h1d20_fff9) found = 1;
    end
    n_compared++;
    if (!found || instr_pc !== RPC + 32'h40) begin
      n_mismatched++;
      $display("FAIL redirect_find: found=%0d pc=%h required pc=%h", found, instr_pc, RPC + 32'h40);
    end
    redirect = 1'b1; redirect_pc = RPC + 32'h24;
    check_issue("redirect_no_issue", 1'b0, 32'h0);
    next_cycle();
    redirect = 1'b0;
    check_issue("redirect_new_addr", 1'b1, RPC + 32'h24);
    n_compared++;
    if (instr_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL redirect_flushed: instr_valid=%b required 0", instr_valid);
    end
    next_cycle();
    check_out("redirect_gap", 1'b0, 32'h0, 32'h0);
    next_cycle();
    check_out("redirect_target", 1'b1, 32'h8d0b_0003, RPC + 32'h24);
  endtask

  task automatic test_redirect_full();
    instr_ready = 1'b0;
    repeat (4) next_cycle();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = RPC + 32'h27;
    check_issue("full_redirect_no_issue", 1'b0, 32'h0);
    next_cycle();
    redirect = 1'b0;
    check_issue("full_redirect_addr", 1'b1, RPC + 32'h24);
    n_compared++;
    if (instr_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL full_redirect_flushed: instr_valid=%b required 0", instr_valid);
    end
    next_cycle();
    check_out("full_redirect_gap", 1'b0, 32'h0, 32'h0);
    next_cycle();
    check_out("full_redirect_target", 1'b1, 32'h8d0b_0003, RPC + 32'h24);
  endtask

  task automatic test_random_stream();
    int start_pops = n_pops;
    for (int i = 0; i < 200; i++) begin
      next_cycle();
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = RPC + 32'($urandom_range(0, 60) * 4) + 32'($urandom_range(0, 3));
    end
    next_cycle();
    redirect = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    n_compared++;
    if (n_pops - start_pops < 40) begin
      n_mismatched++;
      $display("FAIL random_progress: pops=%0d required >= 40", n_pops - start_pops);
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b0;
    check_issue("midreset_no_issue", 1'b0, 32'h0);
    next_cycle();
    reset = 1'b1; instr_ready = 1'b1;
    check_out("midreset_empty", 1'b0, 32'h0, 32'h0);
    n_compared++;
    if (imem_en !== 1'b1 || imem_addr !== RPC) begin
      n_mismatched++;
      $display("FAIL midreset_restart: en=%b addr=%h required en=1 addr=%h", imem_en, imem_addr, RPC);
    end
    next_cycle();
    check_out("midreset_gap", 1'b0, 32'h0, 32'h0);
    next_cycle();
    check_out("midreset_first", 1'b1, 32'h3c01_1001, RPC);
  endtask

  initial begin
    for (int i = 0; i < 40; i++) prog[i] = 32'h2000_0000 + 32'(i) * 32'h0001_0101;
    prog[0]  = 32'h3c01_1001;
    prog[1]  = 32'h3428_0000;
    prog[2]  = 32'h000d_2820;
    prog[9]  = 32'h8d0b_0003;
    prog[16] = 32'h1d20_fff9;
    prog[39] = 32'h03e0_0008;
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;

    test_reset();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_random_stream();
    test_reset_mid();
    repeat (20) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
